// File: rtl/gray_pkg.sv
// gray_pkg: FSM state type and Gray-to-binary conversion shared by Gray-coded designs.
package gray_pkg;

    typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

    // Zero-extended Gray input converts correctly since the leading zeros XOR away.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous bus.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clki,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clki or negedge resetn)
        if (!resetn) {meta, q} <= '0;
        else         {meta, q} <= {d, meta};

endmodule

// File: rtl/gray_reader.sv
// gray_reader: debounced Gray-code reader producing binary value, step pulses and a position count.
module gray_reader
    import gray_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 16,
    parameter int POS_W         = 16
) (
    input  logic             clki,
    input  logic             resetn,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic [POS_W-1:0] pos,
    output logic             step_valid,
    output logic             step_dir,
    output logic             valid,
    output logic             err
);

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync, cand, accepted, acc_code, last, bin_new, d;
    logic [7:0]       cnt, cnt_nxt;
    logic             load, hit, acc, acc_nxt, up, dn, bad;
    state_t           state, state_nxt;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clki   (clki),
        .resetn (resetn),
        .d      (gray_in),
        .q      (sync)
    );

    // A pending acceptance is compared against too, so back-to-back accepts see fresh history.
    always_comb begin
        load    = sync != cand;
        cnt_nxt = load ? 8'd0 : (cnt == LAST ? cnt : cnt + 8'd1);
        hit     = cnt_nxt == LAST && (load || cnt != LAST);
        last    = acc ? acc_code : accepted;
        acc_nxt = (state == INIT && !acc && cnt_nxt == LAST) || (hit && sync != last);
    end

    always_ff @(posedge clki or negedge resetn)
        if (!resetn) begin
            cand     <= '0;
            cnt      <= '0;
            acc      <= 1'b0;
            acc_code <= '0;
        end else begin
            cand     <= sync;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            acc_code <= sync;
        end

    always_ff @(posedge clki or negedge resetn)
        if (!resetn) state <= INIT;
        else         state <= state_nxt;

    always_comb state_nxt = acc ? TRACK : state;

    always_comb begin
        bin_new = WIDTH'(gray2bin(32'(acc_code)));
        d       = bin_new - bin_out;
        up      = acc && state == TRACK && d == WIDTH'(1);
        dn      = acc && state == TRACK && d == '1;
        bad     = acc && state == TRACK && !up && !dn;
    end

    always_ff @(posedge clki or negedge resetn)
        if (!resetn) begin
            accepted   <= '0;
            bin_out    <= '0;
            pos        <= '0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            accepted   <= acc ? acc_code : accepted;
            bin_out    <= acc ? bin_new : bin_out;
            pos        <= up ? pos + POS_W'(1) : dn ? pos - POS_W'(1) : pos;
            step_valid <= up || dn;
            step_dir   <= up;
            valid      <= valid || acc;
            err        <= bad || (err && !err_clr);
        end

endmodule
